// File: rtl/mode_pkg.sv
// -----------------------------------------------------------------------------
// mode_pkg
//
// Shared definitions for the mode transition sequencer.
//
// Contents:
//   seq_state_e        - sequencer state encodings, also exported on the debug
//                        seq_state port (0..5)
//   OWNER_SHELL/CPU    - SRAM bus mux select values
//   state_*()          - per-state output decode, so the registered outputs
//                        are derived from the next state in a single place
// -----------------------------------------------------------------------------
package mode_pkg;

   localparam int SEQ_STATE_W = 3;

   typedef enum logic [SEQ_STATE_W-1:0] {
      SEQ_SHELL     = 3'd0,
      SEQ_DRAIN_SH  = 3'd1,
      SEQ_GRANT_CPU = 3'd2,
      SEQ_APP       = 3'd3,
      SEQ_DRAIN_CPU = 3'd4,
      SEQ_RELEASE   = 3'd5
   } seq_state_e;

   localparam logic OWNER_SHELL = 1'b0;
   localparam logic OWNER_CPU   = 1'b1;

   // Bus mux select for a state. The CPU owns the bus from the grant until
   // the release guard cycle has completed.
   function automatic logic state_owner(input seq_state_e s);
      case (s)
         SEQ_GRANT_CPU, SEQ_APP, SEQ_DRAIN_CPU, SEQ_RELEASE: return OWNER_CPU;
         default:                                             return OWNER_SHELL;
      endcase
   endfunction

   // The CPU runs only while it owns the bus and is either in steady state or
   // finishing its last in-flight access.
   function automatic logic state_cpu_run(input seq_state_e s);
      return (s == SEQ_APP) || (s == SEQ_DRAIN_CPU);
   endfunction

   // The shell is fenced off the SRAM everywhere except its own steady state.
   function automatic logic state_shell_hold(input seq_state_e s);
      return (s != SEQ_SHELL);
   endfunction

   // Any state that is not a steady state is part of a handover.
   function automatic logic state_switching(input seq_state_e s);
      return (s != SEQ_SHELL) && (s != SEQ_APP);
   endfunction

endpackage : mode_pkg

// File: rtl/mode_seq_counter.sv
// -----------------------------------------------------------------------------
// mode_seq_counter
//
// Loadable, saturating down-counter. The sequencer uses it both as the drain
// timeout and as the CPU reset hold timer.
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high reset (count returns to 0)
//   load      in   load load_val this cycle (wins over dec)
//   load_val  in   CNT_W-bit value to load
//   dec       in   decrement this cycle; holds at 0
//   zero      out  the count expires this cycle: a decrement now lands on 0
// -----------------------------------------------------------------------------
module mode_seq_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // NOTE: every signal written in an always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // A value of N therefore lasts exactly N decrementing cycles: the caller
   // leaves its wait state on the same edge that the count reaches 0.
   assign zero = (count_q <= CNT_W'(1));

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its pre-edge inputs regardless of block ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule : mode_seq_counter

// File: rtl/mode_transition_sequencer.sv
// -----------------------------------------------------------------------------
// mode_transition_sequencer
//
// Converts each edge of the app_mode level into an ordered handover of the
// shared SRAM bus between the shell engine and the CPU:
//   shell -> app : fence shell, wait for it to go idle, grant bus to the CPU
//                  while it is held in reset, then release the CPU.
//   app -> shell : let the CPU finish its in-flight access, put it back in
//                  reset, spend one guard cycle, then return the bus.
// Each drain is bounded by DRAIN_TIMEOUT; a forced drain sets a sticky error.
//
// Ports:
//   clk                in   system clock
//   reset              in   synchronous, active-high reset
//   app_mode           in   requested mode: 0 = shell, 1 = application
//   shell_busy         in   shell engine has an SRAM access in flight
//   cpu_mem_valid      in   CPU bus request asserted
//   cpu_mem_ready      in   CPU bus request completing this cycle
//   cpu_resetn         out  active-low CPU reset
//   bus_owner          out  SRAM mux select: 0 = shell, 1 = CPU
//   shell_hold         out  shell must not start new SRAM accesses
//   switching          out  a handover is in progress
//   seq_state          out  current state encoding (debug)
//   drain_timeout_err  out  sticky: a drain was forced by timeout
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module mode_transition_sequencer
   import mode_pkg::*;
#(
   parameter int RESET_HOLD    = 16,
   parameter int DRAIN_TIMEOUT = 255,
   parameter int CNT_W         = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   app_mode,
   input  logic                   shell_busy,
   input  logic                   cpu_mem_valid,
   input  logic                   cpu_mem_ready,
   output logic                   cpu_resetn,
   output logic                   bus_owner,
   output logic                   shell_hold,
   output logic                   switching,
   output logic [SEQ_STATE_W-1:0] seq_state,
   output logic                   drain_timeout_err
);

   localparam logic [CNT_W-1:0] HOLD_VAL    = CNT_W'(RESET_HOLD);
   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(DRAIN_TIMEOUT);

   // ---------------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------------
   seq_state_e state_q,      state_d;
   logic       cpu_resetn_q, cpu_resetn_d;
   logic       bus_owner_q,  bus_owner_d;
   logic       shell_hold_q, shell_hold_d;
   logic       switching_q,  switching_d;
   logic       err_q,        err_d;

   // Counter control
   logic             cnt_load;
   logic [CNT_W-1:0] cnt_val;
   logic             cnt_dec;
   logic             cnt_zero;

   // A CPU access is over either when nothing is requested or when the
   // outstanding request completes in this very cycle.
   logic cpu_idle;
   logic forced;

   assign cpu_idle = !cpu_mem_valid || cpu_mem_ready;

   mode_seq_counter #(
      .CNT_W (CNT_W)
   ) u_counter (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      cnt_load = 1'b0;
      cnt_val  = '0;
      cnt_dec  = 1'b0;
      forced   = 1'b0;

      case (state_q)
         SEQ_SHELL: begin
            if (app_mode) begin
               state_d  = SEQ_DRAIN_SH;
               cnt_load = 1'b1;
               cnt_val  = TIMEOUT_VAL;
            end
         end

         // Idle wins over expiry: a shell that goes quiet in the last
         // timeout cycle is a clean drain, not a forced one.
         SEQ_DRAIN_SH: begin
            cnt_dec = 1'b1;
            if (!shell_busy || cnt_zero) begin
               state_d  = SEQ_GRANT_CPU;
               cnt_load = 1'b1;
               cnt_val  = HOLD_VAL;
               forced   = shell_busy;
            end
         end

         SEQ_GRANT_CPU: begin
            cnt_dec = 1'b1;
            if (cnt_zero) begin
               state_d = SEQ_APP;
            end
         end

         SEQ_APP: begin
            if (!app_mode) begin
               state_d  = SEQ_DRAIN_CPU;
               cnt_load = 1'b1;
               cnt_val  = TIMEOUT_VAL;
            end
         end

         SEQ_DRAIN_CPU: begin
            cnt_dec = 1'b1;
            if (cpu_idle || cnt_zero) begin
               state_d = SEQ_RELEASE;
               forced  = !cpu_idle;
            end
         end

         SEQ_RELEASE: begin
            state_d = SEQ_SHELL;
         end

         default: begin
            state_d = SEQ_SHELL;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registered outputs, decoded from the next state so they change on the
   // same edge as the state itself.
   // ---------------------------------------------------------------------------
   always_comb begin
      bus_owner_d  = state_owner(state_d);
      cpu_resetn_d = state_cpu_run(state_d);
      shell_hold_d = state_shell_hold(state_d);
      switching_d  = state_switching(state_d);
      err_d        = err_q || forced;
   end

   // NOTE: reset here is synchronous, so it is sampled only on a clock edge
   // and belongs inside the clocked branch rather than the sensitivity list.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= SEQ_SHELL;
         cpu_resetn_q <= 1'b0;
         bus_owner_q  <= OWNER_SHELL;
         shell_hold_q <= 1'b0;
         switching_q  <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cpu_resetn_q <= cpu_resetn_d;
         bus_owner_q  <= bus_owner_d;
         shell_hold_q <= shell_hold_d;
         switching_q  <= switching_d;
         err_q        <= err_d;
      end
   end

   assign cpu_resetn        = cpu_resetn_q;
   assign bus_owner         = bus_owner_q;
   assign shell_hold        = shell_hold_q;
   assign switching         = switching_q;
   assign seq_state         = state_q;
   assign drain_timeout_err = err_q;

endmodule : mode_transition_sequencer

// File: tb/tb_mode_transition_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mode_transition_sequencer
//
// Directed bench for mode_transition_sequencer with default parameters
// (RESET_HOLD=16, DRAIN_TIMEOUT=255). Inputs change just after the falling
// edge; outputs are sampled on the falling edge, i.e. half a cycle after the
// rising edge that produced them.
// -----------------------------------------------------------------------------
module tb_mode_transition_sequencer;

   localparam int S_SHELL     = 0;
   localparam int S_DRAIN_SH  = 1;
   localparam int S_GRANT_CPU = 2;
   localparam int S_APP       = 3;
   localparam int S_DRAIN_CPU = 4;
   localparam int S_RELEASE   = 5;

   localparam int HOLD    = 16;
   localparam int TIMEOUT = 255;

   logic       clk           = 1'b0;
   logic       reset         = 1'b1;
   logic       app_mode      = 1'b0;
   logic       shell_busy    = 1'b0;
   logic       cpu_mem_valid = 1'b0;
   logic       cpu_mem_ready = 1'b0;
   logic       cpu_resetn;
   logic       bus_owner;
   logic       shell_hold;
   logic       switching;
   logic [2:0] seq_state;
   logic       drain_timeout_err;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mode_transition_sequencer dut (
      .clk               (clk),
      .reset             (reset),
      .app_mode          (app_mode),
      .shell_busy        (shell_busy),
      .cpu_mem_valid     (cpu_mem_valid),
      .cpu_mem_ready     (cpu_mem_ready),
      .cpu_resetn        (cpu_resetn),
      .bus_owner         (bus_owner),
      .shell_hold        (shell_hold),
      .switching         (switching),
      .seq_state         (seq_state),
      .drain_timeout_err (drain_timeout_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected outputs for each state: {bus_owner, cpu_resetn, shell_hold, switching}
   task automatic expect_st(input string tag, input int st, input logic err);
      logic [3:0] row;
      case (st)
         S_SHELL:     row = 4'b0000;
         S_DRAIN_SH:  row = 4'b0011;
         S_GRANT_CPU: row = 4'b1011;
         S_APP:       row = 4'b1110;
         S_DRAIN_CPU: row = 4'b1111;
         default:     row = 4'b1011;   // S_RELEASE
      endcase
      check({tag, ".state"}, 32'(seq_state),         32'(st));
      check({tag, ".owner"}, 32'(bus_owner),         32'(row[3]));
      check({tag, ".rstn"},  32'(cpu_resetn),        32'(row[2]));
      check({tag, ".hold"},  32'(shell_hold),        32'(row[1]));
      check({tag, ".sw"},    32'(switching),         32'(row[0]));
      check({tag, ".err"},   32'(drain_timeout_err), 32'(err));
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   // Running check: the bus mux may not move across an edge where the CPU was
   // out of reset going into that edge (reset edges excluded).
   logic mon_rst;
   logic prev_owner = 1'b0;
   logic prev_rstn  = 1'b0;
   bit   mon_en     = 1'b0;

   always @(posedge clk) begin
      mon_rst = reset;
      #2;
      if (mon_en && !mon_rst && prev_rstn)
         check("owner_stable", 32'(bus_owner), 32'(prev_owner));
      prev_owner = bus_owner;
      prev_rstn  = cpu_resetn;
   end

   initial begin
      // ---- reset state ----
      repeat (2) cyc();
      expect_st("rst", S_SHELL, 1'b0);
      reset  = 1'b0;
      mon_en = 1'b1;
      cyc();
      expect_st("idle", S_SHELL, 1'b0);

      // ---- shell -> app with an idle shell: 1 drain cycle + HOLD grant cycles ----
      app_mode   = 1'b1;
      shell_busy = 1'b0;
      cyc();
      expect_st("t1_drain", S_DRAIN_SH, 1'b0);
      for (int i = 0; i < HOLD; i++) begin
         cyc();
         expect_st("t1_grant", S_GRANT_CPU, 1'b0);
      end
      cyc();
      expect_st("t1_app", S_APP, 1'b0);
      cyc();
      expect_st("t1_app2", S_APP, 1'b0);

      // ---- app -> shell with CPU stalled for 5 cycles, then completing ----
      app_mode      = 1'b0;
      cpu_mem_valid = 1'b1;
      cpu_mem_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         expect_st("t2_drain", S_DRAIN_CPU, 1'b0);
      end
      cpu_mem_ready = 1'b1;
      cyc();
      expect_st("t2_release", S_RELEASE, 1'b0);
      cpu_mem_valid = 1'b0;
      cpu_mem_ready = 1'b0;
      cyc();
      expect_st("t2_shell", S_SHELL, 1'b0);
      cyc();
      expect_st("t2_shell2", S_SHELL, 1'b0);

      // ---- shell goes idle in the very cycle the timeout expires: no error ----
      app_mode   = 1'b1;
      shell_busy = 1'b1;
      for (int i = 0; i < TIMEOUT; i++) begin
         cyc();
         expect_st("t3b_drain", S_DRAIN_SH, 1'b0);
      end
      shell_busy = 1'b0;
      cyc();
      expect_st("t3b_grant", S_GRANT_CPU, 1'b0);

      // ---- app_mode drops during GRANT_CPU: APP is still reached, then DRAIN_CPU ----
      app_mode = 1'b0;
      for (int i = 1; i < HOLD; i++) begin
         cyc();
         expect_st("t4_grant", S_GRANT_CPU, 1'b0);
      end
      cyc();
      expect_st("t4_app", S_APP, 1'b0);
      cyc();
      expect_st("t4_drain", S_DRAIN_CPU, 1'b0);
      cyc();
      expect_st("t4_release", S_RELEASE, 1'b0);
      cyc();
      expect_st("t4_shell", S_SHELL, 1'b0);

      // ---- shell stays busy: forced handover after TIMEOUT cycles, sticky error ----
      app_mode   = 1'b1;
      shell_busy = 1'b1;
      for (int i = 0; i < TIMEOUT; i++) begin
         cyc();
         expect_st("t3_drain", S_DRAIN_SH, 1'b0);
      end
      cyc();
      expect_st("t3_grant", S_GRANT_CPU, 1'b1);
      shell_busy = 1'b0;
      for (int i = 1; i < HOLD; i++) begin
         cyc();
         expect_st("t3_grant_n", S_GRANT_CPU, 1'b1);
      end
      cyc();
      expect_st("t3_app", S_APP, 1'b1);

      // ---- reset during DRAIN_CPU with the CPU running: immediate abort ----
      app_mode      = 1'b0;
      cpu_mem_valid = 1'b1;
      cpu_mem_ready = 1'b0;
      cyc();
      expect_st("t5_drain", S_DRAIN_CPU, 1'b1);
      cyc();
      expect_st("t5_drain2", S_DRAIN_CPU, 1'b1);
      reset = 1'b1;
      cyc();
      expect_st("t5_abort", S_SHELL, 1'b0);
      reset         = 1'b0;
      cpu_mem_valid = 1'b0;
      cyc();
      expect_st("t5_after", S_SHELL, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_mode_transition_sequencer
